// File: rtl/arbiter_rr.sv
// Two-requester round-robin arbiter with a bounded hold time.
// The current owner keeps the grant until it drops its request or, while the
// other requester waits, until it has held the grant for MAX_HOLD cycles.
module arbiter_rr #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] request,
    output logic [1:0] grant,
    output logic       timeout
);

    localparam int unsigned         CNT_W      = 8;
    localparam logic [CNT_W-1:0]    HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G0   = 2'd1,
        G1   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             last;
    logic             last_next;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_next;
    logic [1:0]       grant_next;
    logic             timeout_next;

    // State, pointer, hold counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            hold_cnt <= '0;
            grant    <= 2'b00;
            timeout  <= 1'b0;
        end else begin
            state    <= state_next;
            last     <= last_next;
            hold_cnt <= hold_next;
            grant    <= grant_next;
            timeout  <= timeout_next;
        end
    end

    // Next-state, pointer and hold-count logic; any grant entry clears hold_cnt.
    always_comb begin
        state_next   = state;
        last_next    = last;
        hold_next    = (hold_cnt == CNT_MAX) ? hold_cnt : hold_cnt + CNT_W'(1);
        timeout_next = 1'b0;

        case (state)
            IDLE: begin
                hold_next = '0;
                case (request)
                    2'b01: begin
                        state_next = G0;
                        last_next  = 1'b0;
                    end
                    2'b10: begin
                        state_next = G1;
                        last_next  = 1'b1;
                    end
                    2'b11: begin
                        if (last) begin
                            state_next = G0;
                            last_next  = 1'b0;
                        end else begin
                            state_next = G1;
                            last_next  = 1'b1;
                        end
                    end
                    default: state_next = IDLE;
                endcase
            end

            G0: begin
                if (!request[0]) begin
                    hold_next = '0;
                    if (request[1]) begin
                        state_next = G1;
                        last_next  = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (request[1] && (hold_cnt >= HOLD_LIMIT)) begin
                    state_next   = G1;
                    last_next    = 1'b1;
                    hold_next    = '0;
                    timeout_next = 1'b1;
                end
            end

            G1: begin
                if (!request[1]) begin
                    hold_next = '0;
                    if (request[0]) begin
                        state_next = G0;
                        last_next  = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (request[0] && (hold_cnt >= HOLD_LIMIT)) begin
                    state_next   = G0;
                    last_next    = 1'b0;
                    hold_next    = '0;
                    timeout_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                hold_next  = '0;
            end
        endcase
    end

    // Grant decode of the next state, registered alongside it.
    always_comb begin
        grant_next = 2'b00;
        case (state_next)
            G0:      grant_next = 2'b01;
            G1:      grant_next = 2'b10;
            default: grant_next = 2'b00;
        endcase
    end

endmodule

// File: doc/arbiter_rr.md
ARBITER_RR -- requirements
Module: arbiter_rr

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive cycles one requester may hold grant while the other requests; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: request  input  2  request[i] asserted = requester i wants the resource; level-sensitive.
REQ-005 Port: grant  output  2  one-hot or zero; grant[i]=1 = requester i owns the resource.
REQ-006 Port: timeout  output  1  one-cycle pulse, asserted in the first cycle of a grant obtained by forced preemption.

Function
REQ-007 The block SHALL be a 3-state FSM: IDLE (grant=00), G0 (grant=01), G1 (grant=10); grant and timeout are registered, with no combinational path from request.
REQ-008 Latency: a request sampled at posedge k SHALL produce its grant in the cycle following posedge k; the grant is visible to a sampler at posedge k+1.
REQ-009 grant SHALL never be 11.
REQ-010 A 1-bit priority pointer last SHALL record the most recent winner and SHALL be updated on every entry into G0 (last=0) or G1 (last=1).
REQ-011 IDLE transitions:
- request=00: stay in IDLE.
- request=01: go to G0.
- request=10: go to G1.
- request=11: go to G0 if last=1, else G1.
REQ-012 An 8-bit hold_cnt SHALL clear to 0 on every entry into G0/G1 and increment by 1 on each cycle spent in the same grant state, saturating at 255.
REQ-013 G0 transitions (G1 is symmetric with indices swapped):
- request[0]=0 and request[1]=1: go to G1 directly, with no IDLE bubble.
- request[0]=0 and request[1]=0: go to IDLE.
- request=11 and hold_cnt >= MAX_HOLD-1: preempt to G1 and assert timeout.
- Otherwise: stay in G0.
REQ-014 Under continuous request=11, grant SHALL alternate, each holder keeping grant for exactly MAX_HOLD cycles; with MAX_HOLD=1, grant toggles every cycle.
REQ-015 If the waiting requester first asserts after the holder's hold_cnt already exceeds MAX_HOLD-1, preemption SHALL occur at the next posedge.
REQ-016 timeout SHALL be 0 in every cycle except the first cycle of a preemption-entered grant; a voluntary hand-over (REQ-013, first bullet) SHALL NOT assert timeout.
REQ-017 A holder that drops and re-raises its request while the other requester is idle SHALL pass through IDLE for one cycle and then be re-granted.

Reset
REQ-018 When rst=1 at posedge clk:
- FSM goes to IDLE.
- grant=00, timeout=0.
- hold_cnt=0 and last=1, so requester 0 wins the first contention.
REQ-019 rst SHALL override any request and any in-progress grant or pending preemption in the same edge.
REQ-020 Outputs are undefined before the first posedge with rst=1; the bench SHALL apply rst for at least 1 cycle.

Verification
REQ-021 Reset, then request=01 driven after the first posedge -> grant=01 observed 2 posedges later; timeout=0 throughout.
REQ-022 Reset, MAX_HOLD=4, request=11 held -> grant=01 for exactly 4 cycles, then 10 for 4 cycles, then 01 again; timeout pulses 1 cycle at each switch.
REQ-023 grant=01, then request changes to 10 -> grant=10 in the next cycle with no 00 cycle and timeout=0.
REQ-024 grant=10, request=10 drops to 00 -> grant=00 in the next cycle; FSM in IDLE.
REQ-025 grant=10 with request=11 and rst asserted 1 cycle -> grant=00 after that edge; on release with request=11 -> grant=01 (pointer reset).
REQ-026 MAX_HOLD=1 build, request=11 held -> grant toggles 01/10 every cycle; timeout=1 on every cycle after the first grant.
